// File: rtl/dma_chan_seq_if.sv
// rtl/dma_chan_seq_if.sv - config, peripheral, bus and status signals of the DMA channel sequencer
interface dma_chan_seq_if #(
    parameter int NBITS = 8
);
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [NBITS-1:0] cfg_wdata;
    logic             start;
    logic             abort;
    logic             dev_req;
    logic             dev_ack;
    logic             bus_req;
    logic             bus_gnt;
    logic             bus_strobe;
    logic [NBITS-1:0] bus_addr;
    logic             busy;
    logic             irq;
    logic             aborted;
    logic [NBITS-1:0] wc;

    modport slave (
        input  cfg_we, cfg_sel, cfg_wdata, start, abort, dev_req, bus_gnt,
        output dev_ack, bus_req, bus_strobe, bus_addr, busy, irq, aborted, wc
    );

    modport master (
        output cfg_we, cfg_sel, cfg_wdata, start, abort, dev_req, bus_gnt,
        input  dev_ack, bus_req, bus_strobe, bus_addr, busy, irq, aborted, wc
    );
endinterface

// File: rtl/dma_chan_seq.sv
// rtl/dma_chan_seq.sv - single DMA channel sequencer (AC/WR/CR/WC, word handshake, termination)
// Optional DMA_AUTO_RELOAD_EN: on termination reload AC from its start value and keep running.
module dma_chan_seq #(
    parameter int NBITS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dma_chan_seq_if.slave  io
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_BREQ,
        S_XFER,
        S_ACK,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [NBITS-1:0] r_ac;
    logic [NBITS-1:0] r_wr;
    logic [NBITS-1:0] r_wc;
    logic [1:0]       r_cr;
    logic             r_irq;
    logic             r_aborted;
`ifdef DMA_AUTO_RELOAD_EN
    logic [NBITS-1:0] r_ac_base;
`endif

    logic             w_active;
    logic             w_cfg_ok;
    logic             w_go;
    logic             w_abort;
    logic             w_term;
    logic [NBITS-1:0] w_wc_next;
    logic [NBITS-1:0] w_ac_next;

    assign w_active  = (r_state == S_ARM) || (r_state == S_BREQ) ||
                       (r_state == S_XFER) || (r_state == S_ACK);
    assign w_cfg_ok  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_go      = w_cfg_ok && io.start;
    assign w_abort   = w_active && io.abort;
    assign w_wc_next = r_wc + NBITS'(1);
    assign w_ac_next = r_ac + NBITS'(1);

    // CR=00 ends on WC carry-out, i.e. WC was all ones before this increment
    always_comb begin
        w_term = 1'b0;
        case (r_cr)
            2'b00:   w_term = &r_wc;
            2'b01:   w_term = (w_wc_next == r_wr);
            2'b10:   w_term = (w_ac_next == r_wr);
            default: w_term = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (io.start)   w_next = S_ARM;
            S_ARM:  if (io.dev_req) w_next = S_BREQ;
            S_BREQ: if (io.bus_gnt) w_next = S_XFER;
            S_XFER: w_next = S_ACK;
            S_ACK: begin
`ifdef DMA_AUTO_RELOAD_EN
                w_next = S_ARM;
`else
                w_next = w_term ? S_DONE : S_ARM;
`endif
            end
            S_DONE: if (io.start)   w_next = S_ARM;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ac      <= '0;
            r_wr      <= '0;
            r_wc      <= '0;
            r_cr      <= 2'b00;
            r_irq     <= 1'b0;
            r_aborted <= 1'b0;
`ifdef DMA_AUTO_RELOAD_EN
            r_ac_base <= '0;
`endif
        end else begin
            if (w_cfg_ok && io.cfg_we) begin
                case (io.cfg_sel)
                    2'b00:   r_ac <= io.cfg_wdata;
                    2'b01:   r_wr <= io.cfg_wdata;
                    2'b10:   r_cr <= io.cfg_wdata[1:0];
                    default: ;
                endcase
            end
            if (w_go) begin
                r_wc      <= '0;
                r_irq     <= 1'b0;
                r_aborted <= 1'b0;
`ifdef DMA_AUTO_RELOAD_EN
                r_ac_base <= r_ac;
`endif
            end
`ifdef DMA_AUTO_RELOAD_EN
            // the reload irq is a single-cycle pulse seen during the first ARM cycle
            if (r_state == S_ARM) r_irq <= 1'b0;
`endif
            if (r_state == S_ACK) begin
`ifdef DMA_AUTO_RELOAD_EN
                if (w_term && !io.abort) begin
                    r_ac  <= r_ac_base;
                    r_wc  <= '0;
                    r_irq <= 1'b1;
                end else begin
                    r_ac <= w_ac_next;
                    r_wc <= w_wc_next;
                end
`else
                r_ac <= w_ac_next;
                r_wc <= w_wc_next;
                if (w_term) r_irq <= 1'b1;
`endif
            end
            // abort in ACK still counts the word: counters above update as usual
            if (w_abort) begin
                r_irq     <= 1'b1;
                r_aborted <= 1'b1;
            end
        end
    end

    assign io.dev_ack    = (r_state == S_ACK);
    assign io.bus_req    = (r_state == S_BREQ) || (r_state == S_XFER);
    assign io.bus_strobe = (r_state == S_XFER);
    assign io.bus_addr   = (r_state == S_XFER) ? r_ac : '0;
    assign io.busy       = w_active;
    assign io.irq        = r_irq;
    assign io.aborted    = r_aborted;
    assign io.wc         = r_wc;
endmodule
